// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-add multiplier, one partial-product step per clock.
//
// The operands are converted to unsigned magnitudes when the operation is accepted.
// WIDTH add/shift iterations run on {acc, q}. A final step applies the sign and
// registers the full 2*WIDTH-bit product.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while busy=0
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   multiplicand operand A (sampled with start)
//   multiplier   operand B (sampled with start)
//   busy         high from the accepting edge until the edge that raises done
//   done         single-cycle pulse, product valid
//   product      2*WIDTH-bit result, held until the next done
module seq_mult_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;      // acc_q[WIDTH] holds the adder carry
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] full;

  // Magnitudes of the incoming operands. -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1),
  // which is the correct unsigned magnitude.
  always_comb begin
    a_neg = signed_mode & multiplicand[WIDTH-1];
    b_neg = signed_mode & multiplier[WIDTH-1];
    a_mag = a_neg ? -multiplicand : multiplicand;
    b_mag = b_neg ? -multiplier : multiplier;
  end

  // One partial-product step. The add is done before the shift so the carry in
  // bit WIDTH shifts down into the accumulator.
  always_comb begin
    sum  = q_q[0] ? ({1'b0, acc_q[WIDTH-1:0]} + {1'b0, mag_a_q}) : acc_q;
    full = {acc_q[WIDTH-1:0], q_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    mag_a_d   = mag_a_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_a_d = a_mag;
          q_d     = b_mag;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = {1'b0, sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        product_d = neg_q ? -full : full;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      mag_a_q   <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      mag_a_q   <= mag_a_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised sequential shift-add multiplier with a start/busy/done handshake and a per-operation signed/unsigned mode. It computes one partial-product step per clock, so it trades latency for area. It sits beside the ALU in the datapath and serves MUL in both signed and unsigned forms. It writes the full 2*WIDTH-bit result, which the control unit splits into the HI/LO registers.

Parameters:
WIDTH, 32, operand width in bits (>= 4); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while busy=0
signed_mode  input  1  1 = operands two's complement, 0 = unsigned; sampled with start
multiplicand  input  WIDTH  operand A; sampled with start
multiplier  input  WIDTH  operand B; sampled with start
busy  output  1  high from the edge that accepts start until the edge that raises done
done  output  1  single-cycle pulse; product valid
product  output  2*WIDTH  result, held until the next done

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. Reset drives the state to IDLE and sets busy=0, done=0, product=0, and counter and internal registers to 0.
- A reset asserted mid-operation aborts the operation. No done pulse is produced for the aborted operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - If start=1, latch the operands and signed_mode, and go to RUN. busy goes to 1 and counter goes to 0.
  - In signed mode, latch |A| and |B| as WIDTH-bit unsigned magnitudes, and latch neg = A[msb] XOR B[msb].
  - In unsigned mode, latch the raw operands and set neg = 0.
  - Initialise the accumulator (WIDTH+1 bits including carry) to 0 and Q to mag(B).
- RUN: performs one iteration per edge.
  - If Q[0]=1, then acc = acc[WIDTH-1:0] + mag(A), with the carry kept in acc[WIDTH].
  - Then shift {acc, Q} right by one, with carry shifting in at the top.
  - counter increments each edge. After the WIDTH-th iteration, go to FIX.
- FIX: one edge.
  - product <= neg ? -{acc[WIDTH-1:0], Q} : {acc[WIDTH-1:0], Q}, taken modulo 2^(2W).
  - done <= 1 and busy <= 0, then return to IDLE.
- done lasts exactly one cycle; it is cleared on the next edge.
- Latency: with start accepted at edge T0, done and product are valid after edge T0+WIDTH+1.
- Throughput: a new start may be applied in the cycle in which done=1, because busy is already 0 then. Back-to-back operation therefore has a period of WIDTH+2 cycles.
- start while busy=1 is ignored, with no queueing. Operand and mode changes while busy have no effect.
- product is not cleared by start; it updates only in FIX.
- Boundary cases:
  - Zero operand gives 0, including in signed mode with the other operand negative (-0 = 0).
  - Signed A = B = -2^(WIDTH-1): magnitudes equal 2^(WIDTH-1) and fit in WIDTH bits; product = 2^(2WIDTH-2).
  - Unsigned all-ones x all-ones = 2^(2W) - 2^(W+1) + 1, so the accumulator carry must not be lost.
- No X propagation from unused inputs. All outputs are registered.

Test Plan:
1. WIDTH=32, unsigned, A=7, B=6 -> busy high for 33 cycles; done pulses once at T0+33; product=42.
2. WIDTH=32, unsigned, A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (carry path).
3. WIDTH=32, signed, A=-3 (0xFFFFFFFD), B=5 -> product=0xFFFFFFFFFFFFFFF1 (-15). With signed_mode=0 and the same bits -> 0x00000004FFFFFFF1.
4. WIDTH=8, signed, A=B=0x80 -> product=0x4000. Also A=0x80, B=0x7F -> 0xC080. Also A=0, B=0x80 -> 0x0000. Latency is 9 cycles.
5. Handshake, WIDTH=8: pulse start with A=3, B=4; re-pulse start with A=9 mid-RUN -> ignored, product=12. Apply start in the done cycle with A=2, B=5 -> accepted immediately; product=10 appears 9 cycles later, and 12 is held until then.
6. Reset: assert rst_n=0 at iteration 10 of a WIDTH=32 multiply -> busy, done and product go to 0 immediately, with no done pulse afterwards. A subsequent start with A=B=2 -> product=4.
